sha256_msg_schedule: RTL and testbench

Sequential SHA-256 message-schedule generator. Accepts one 512-bit message block as 16 big-endian 32-bit words over a valid/ready input stream. It then emits the 64 schedule words W[0..63] over a valid/ready output stream to the compression-round datapath. Expansion uses the existing low_sigma_0_func and low_sigma_1_func blocks on a 16-word sliding window, so no 64-entry storage is needed.

---
 rtl/sha256_msg_schedule.sv | 117 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads one 16-word block over a valid/ready
// stream, then emits W[0..NUM_ROUNDS-1] from a 16-word sliding window.
module sha256_msg_schedule #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        busy,
  output logic        block_done
);

  if (NUM_ROUNDS < 16 || NUM_ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_schedule: NUM_ROUNDS must be in 16..64");
  end

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;
  logic [31:0] w_next;

  function automatic logic [31:0] low_sigma_0_func(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] low_sigma_1_func(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win_q[0] is W[t], so win_q[15] holds W[t+15] and the new entry is W[t+16].
  assign w_next = low_sigma_1_func(win_q[14]) + win_q[9]
                + low_sigma_0_func(win_q[1]) + win_q[0];

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    done_d   = 1'b0;

    if (clr) begin
      state_d  = LOAD;
      ld_cnt_d = '0;
      t_d      = '0;
      for (int unsigned i = 0; i < 16; i++) win_d[i] = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = in_word;
            ld_cnt_d  = ld_cnt_q + 4'd1;
            if (ld_cnt_q == 4'd15) begin
              state_d  = EMIT;
              ld_cnt_d = '0;
              t_d      = '0;
            end
          end
        end
        EMIT: begin
          if (w_ready) begin
            for (int unsigned i = 0; i < 15; i++) win_d[i] = win_q[i+1];
            win_d[15] = w_next;
            t_d       = t_q + 6'd1;
            if (t_q == LAST_T) begin
              state_d = LOAD;
              t_d     = '0;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      ld_cnt_q <= '0;
      t_q      <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
      done_q   <= done_d;
      win_q    <= win_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign w_valid    = (state_q == EMIT);
  assign w_word     = win_q[0];
  assign w_idx      = t_q;
  assign busy       = (state_q == EMIT) || (ld_cnt_q != 4'd0);
  assign block_done = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule against a textbook W[t] recurrence model.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        busy;
  logic        block_done;

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_word     (w_word),
    .w_idx      (w_idx),
    .busy       (busy),
    .block_done (block_done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int first_cyc = 0;
  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_zero();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    build_model();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_block(input bit keep_valid);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = blk[i];
      if (i == 0) first_cyc = cyc;
      chk("in_ready_load", 32'(in_ready), 32'd1);
      chk("w_valid_load", 32'(w_valid), 32'd0);
      tick();
      if (i == 0) chk("busy_after_first", 32'(busy), 32'd1);
    end
    in_valid = keep_valid;
  endtask

  // Returns in the block_done cycle (or right after clr when abort_at30 is set).
  task automatic emit_block(input bit is_abc, input bit stall, input bit abort_at30);
    for (int k = 0; k < 64; k++) begin
      w_ready = 1'b1;
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_idx", 32'(w_idx), 32'(k));
      chk("w_word", w_word, exp_w[k]);
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      if (k == 0) chk("done_idle", 32'(block_done), 32'd0);
      if (is_abc && k == 16) chk("W16", w_word, 32'h61626380);
      if (is_abc && k == 17) chk("W17", w_word, 32'h000F0000);
      if (stall && k == 20) begin
        for (int s = 0; s < 5; s++) begin
          w_ready  = 1'b0;
          in_valid = s[0];
          in_word  = $urandom;
          tick();
          chk("stall_idx", 32'(w_idx), 32'd20);
          chk("stall_word", w_word, exp_w[20]);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_valid", 32'(w_valid), 32'd1);
        end
        in_valid = 1'b0;
        w_ready  = 1'b1;
      end
      if (abort_at30 && k == 30) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_w_valid", 32'(w_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(block_done), 32'd0);
        chk("clr_w_idx", 32'(w_idx), 32'd0);
        tick();
        chk("clr_done_later", 32'(block_done), 32'd0);
        return;
      end
      tick();
    end
    chk("block_done", 32'(block_done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    chk("done_w_valid", 32'(w_valid), 32'd0);
    if (!stall) chk("done_latency", 32'(cyc - first_cyc), 32'd80);
  endtask

  initial begin
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_word  = 32'h0;
    w_ready  = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_w_valid", 32'(w_valid), 32'd0);
    chk("rst_w_word", w_word, 32'h0);
    chk("rst_w_idx", 32'(w_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(block_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // "abc" block, no backpressure
    set_abc();
    load_block(1'b0);
    emit_block(1'b1, 1'b0, 1'b0);
    tick();
    chk("done_once", 32'(block_done), 32'd0);

    // all-zero block
    set_zero();
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 1'b0);
    tick();
    chk("done_once_zero", 32'(block_done), 32'd0);

    // backpressure at W20 with in_valid toggling
    set_abc();
    load_block(1'b0);
    emit_block(1'b1, 1'b1, 1'b0);
    tick();

    // clr at W30, then a clean abc block
    load_block(1'b0);
    emit_block(1'b1, 1'b0, 1'b1);
    load_block(1'b0);
    emit_block(1'b1, 1'b0, 1'b0);
    tick();

    // asynchronous reset after 7 words
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_word  = 32'hDEAD0000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_w_valid", 32'(w_valid), 32'd0);
    chk("arst_w_word", w_word, 32'h0);
    chk("arst_w_idx", 32'(w_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(block_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_block(1'b0);
    emit_block(1'b1, 1'b0, 1'b0);
    tick();

    // back-to-back: abc then zero with in_valid held high
    load_block(1'b1);
    emit_block(1'b1, 1'b0, 1'b0);
    set_zero();
    load_block(1'b0);
    emit_block(1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_done_once", 32'(block_done), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
